// File: rtl/console_pkg.sv
// console_pkg: shared types and constants for the console write arbiter.
// Imported by console_write_arbiter and rr_arbiter.
package console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    PACE,
    CLEAR
  } arb_state_t;

  localparam int         CHAR_W  = 8;
  localparam logic [7:0] CHAR_LF = 8'd10;
  localparam logic [7:0] CHAR_CR = 8'd13;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Returns the first request at or after the pointer.
module rr_arbiter
  import console_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o   = IW'((int'(ptr_i) + k) % N);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/console_write_arbiter.sv
// console_write_arbiter: round-robin share of one console writer.
// CONSOLE_ARB_TIMEOUT_EN revokes a stalled grant after TIMEOUT cycles.
module console_write_arbiter
  import console_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*CHAR_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       clear_req,
  output logic                       clear_ack,
  output logic                       out_write,
  output logic                       out_clear,
  output logic [CHAR_W-1:0]          out_character,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int PW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [PW-1:0] PACE_LAST = PW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [PW-1:0] PACE_MAX  = PW'(GAP);
  localparam logic [IW-1:0] LAST_ID   = IW'(N_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [PW-1:0]     pace_q, pace_d;
  logic              done_q, done_d;
  logic              write_q, write_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [IW-1:0]     arb_idx;
  logic              arb_found;
  logic [IW-1:0]     next_id;

`ifdef CONSOLE_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
  logic [SW-1:0] stall_q, stall_d;
`endif

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .idx_o   (arb_idx),
    .found_o (arb_found)
  );

  assign next_id = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    pace_d    = pace_q;
    done_d    = done_q;
    write_d   = 1'b0;
    char_d    = char_q;
    req_ready = '0;
    out_clear = 1'b0;
    clear_ack = 1'b0;
`ifdef CONSOLE_ARB_TIMEOUT_EN
    stall_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
        end else if (arb_found) begin
          grant_d = arb_idx;
          state_d = LOCK;
        end
      end
      LOCK: begin
        req_ready[grant_q] = 1'b1;
        if (req_valid[grant_q]) begin
          write_d = 1'b1;
          char_d  = req_data[grant_q*CHAR_W +: CHAR_W];
          pace_d  = '0;
          done_d  = req_last[grant_q];
          if (req_last[grant_q]) rr_d = next_id;
          if (GAP > 0) state_d = PACE;
          else if (req_last[grant_q]) state_d = IDLE;
        end
`ifdef CONSOLE_ARB_TIMEOUT_EN
        // Revoked requester resumes as a fresh message later.
        else if (stall_q == STALL_LAST) begin
          state_d = IDLE;
          rr_d    = next_id;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      PACE: begin
        pace_d = (pace_q == PACE_MAX) ? pace_q : pace_q + 1'b1;
        if (pace_q == PACE_LAST) state_d = done_q ? IDLE : LOCK;
      end
      CLEAR: begin
        out_clear = 1'b1;
        clear_ack = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      pace_q  <= '0;
      done_q  <= 1'b0;
      write_q <= 1'b0;
      char_q  <= '0;
`ifdef CONSOLE_ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      pace_q  <= pace_d;
      done_q  <= done_d;
      write_q <= write_d;
      char_q  <= char_d;
`ifdef CONSOLE_ARB_TIMEOUT_EN
      stall_q <= stall_d;
`endif
    end
  end

  assign out_write     = write_q;
  assign out_character = char_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);

endmodule
